// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - state_e    : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   - F3_*       : RISC-V load/store funct3 size codes
//   - REQ_*      : requester indices (core = 0, debug/loader = 1)
//   - misaligned : alignment test used when DMEM_ARB_ALIGN_CHECK_EN is defined
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Byte accesses are always aligned; halves need addr[0] == 0, words addr[1:0] == 0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (f3 == F3_W && a != 2'b00)
            bad = 1'b1;
        else if ((f3 == F3_H || f3 == F3_HU) && a[0])
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] : request vector
//   last     : index of the requester granted most recently
//   gnt[1:0] : one-hot grant (zero when no request)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;  // contention: favour the one not served last
        else
            gnt = req;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store
// stage (requester 0) and the debug/loader (requester 1). Round-robin
// grant, registered request capture, one access in flight; load data
// comes back as a one-cycle pulse on rsp_valid two cycles after accept.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/write/addr/wdata/funct3  per-requester request channel
//   req_ready[1:0]                 one-hot accept (valid & ready = handshake)
//   rsp_valid[1:0], rsp_rdata      one-hot response pulse, load data
//   rsp_err                        misaligned-access flag (only with macro)
//   mem_read/write/addr/wd/funct3  to the memory instance
//   mem_rd                         read data from memory
//
// Optional: define DMEM_ARB_ALIGN_CHECK_EN to add rsp_err and suppress
// memory strobes for misaligned half/word accesses.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing in flight; requests may be accepted
// ACCESS | memory strobe cycle for the latched request; rd captured at end
// RESP   | response pulse to owner; a new request may be accepted
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_write,
    input  logic [1:0][DM_ADDRESS-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0]     req_wdata,
    input  logic [1:0][2:0]            req_funct3,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic                       rsp_err,
`endif
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DM_ADDRESS-1:0]      mem_addr,
    output logic [DATA_W-1:0]          mem_wd,
    output logic [2:0]                 mem_funct3,
    input  logic [DATA_W-1:0]          mem_rd
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]            state_q;
    logic                  last_owner_q;
    logic                  owner_q;
    logic                  write_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            funct3_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [1:0] gnt;
    logic       accept_win;
    logic       grant;
    logic       gnt_idx;
    logic       in_access;
    logic       in_resp;
    logic       bad;

    rr_arb2 u_rr_arb2 (
        .req  (req_valid),
        .last (last_owner_q),
        .gnt  (gnt)
    );

    assign accept_win = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign req_ready  = accept_win ? gnt : 2'b00;
    assign grant      = |req_ready;
    assign gnt_idx    = req_ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= REQ_DBG;
            owner_q      <= REQ_CORE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (grant) begin
                        state_q      <= ST_ACCESS;
                        owner_q      <= gnt_idx;
                        last_owner_q <= gnt_idx;
                        write_q      <= req_write[gnt_idx];
                        addr_q       <= req_addr[gnt_idx];
                        wdata_q      <= req_wdata[gnt_idx];
                        funct3_q     <= req_funct3[gnt_idx];
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= mem_rd;
                    state_q <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bad     = misaligned(funct3_q, addr_q[1:0]);
    assign rsp_err = in_resp & bad;
`else
    assign bad = 1'b0;
`endif

    assign mem_read   = in_access & ~write_q & ~bad;
    assign mem_write  = in_access &  write_q & ~bad;
    assign mem_addr   = addr_q;
    assign mem_wd     = wdata_q;
    assign mem_funct3 = funct3_q;

    assign rsp_valid = in_resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    // Stores and rejected accesses return zero data.
    assign rsp_rdata = (in_resp & ~write_q & ~bad) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a word-wide memory
// model and a response scoreboard. Define DMEM_ARB_ALIGN_CHECK_EN to also
// exercise the misalignment path.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_write;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0][2:0]    req_funct3;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [DW-1:0]      rsp_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic               rsp_err;
`endif
    logic               mem_read;
    logic               mem_write;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wd;
    logic [2:0]         mem_funct3;
    logic [DW-1:0]      mem_rd;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        .rsp_err    (rsp_err),
`endif
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_funct3 (mem_funct3),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Memory the DUT talks to, and a shadow copy updated at accept time.
    logic [DW-1:0] tbmem   [128];
    logic [DW-1:0] ref_mem [128];

    assign mem_rd = tbmem[mem_addr[8:2]];
    always @(negedge clk) if (mem_write) tbmem[mem_addr[8:2]] = mem_wd;

    typedef struct {
        logic          owner;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tb_misaligned(input logic [2:0] f, input logic [AW-1:0] a);
        return (f == 3'b010 && a[1:0] != 2'b00) || ((f == 3'b001 || f == 3'b101) && a[0]);
    endfunction

    // Scoreboard: push on handshake, pop and compare on response.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.owner = (i == 1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                    e.err = tb_misaligned(req_funct3[i], req_addr[i]);
`else
                    e.err = 1'b0;
`endif
                    if (req_write[i]) begin
                        e.rdata = '0;
                        if (!e.err) ref_mem[req_addr[i][8:2]] = req_wdata[i];
                    end else begin
                        e.rdata = e.err ? '0 : ref_mem[req_addr[i][8:2]];
                    end
                    sb.push_back(e);
                end
            end
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", rsp_valid, e.owner ? 2'b10 : 2'b01);
                    check("rsp_rdata", rsp_rdata, e.rdata);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                    check("rsp_err", rsp_err, e.err);
`endif
                end
            end
        end
    end

    task automatic drive(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] f);
        req_write[i]  = w;
        req_addr[i]   = a;
        req_wdata[i]  = d;
        req_funct3[i] = f;
        req_valid[i]  = 1'b1;
    endtask

    // Returns #1 after the accepting edge (arbiter then in ACCESS).
    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] f);
        bit ok;
        ok = 0;
        drive(i, w, a, d, f);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) check("accept_timeout", req_ready[i], 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int wcnt;
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        for (int k = 0; k < 128; k++) begin
            tbmem[k]   = (k * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[k] = tbmem[k];
        end
        tbmem[4]   = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid",  rsp_valid,  0);
        check("rst_rsp_rdata",  rsp_rdata,  0);
        check("rst_mem_read",   mem_read,   0);
        check("rst_mem_write",  mem_write,  0);
        check("rst_mem_addr",   mem_addr,   0);
        check("rst_mem_wd",     mem_wd,     0);
        check("rst_mem_funct3", mem_funct3, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single load from requester 0: accept N, strobe N+1, data N+2
        drive(0, 1'b0, 9'h010, 32'h0, 3'b010);
        @(negedge clk);
        check("t1_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_mem_read",   mem_read,   1);
        check("t1_mem_write",  mem_write,  0);
        check("t1_mem_addr",   mem_addr,   9'h010);
        check("t1_mem_funct3", mem_funct3, 3'b010);
        check("t1_rsp_early",  rsp_valid,  0);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("t1_read_drop", mem_read,  0);
        @(posedge clk); #1;

        // Store from requester 1, then load it back
        issue(1, 1'b1, 9'h020, 32'h1234_5678, 3'b010);
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_write) begin
                wcnt++;
                check("t2_mem_wd",   mem_wd,   32'h1234_5678);
                check("t2_mem_addr", mem_addr, 9'h020);
            end
        end
        check("t2_write_cycles", wcnt, 1);
        check("t2_mem_content", tbmem[8], 32'h1234_5678);
        @(posedge clk); #1;
        issue(1, 1'b0, 9'h020, 32'h0, 3'b010);
        drain();

        // Both requesters held valid after reset: grants 0,1,0,1 every 2 cycles
        do_reset();
        drive(0, 1'b0, 9'h010, 32'h0, 3'b010);
        drive(1, 1'b0, 9'h020, 32'h0, 3'b010);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t3_ready", req_ready, (k % 2 != 0) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();

        // Reset during ACCESS of a store: no response, outputs cleared
        issue(0, 1'b1, 9'h030, 32'hAAAA_5555, 3'b010);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("t4_wr_strobe", mem_write, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t4_rsp_valid",  rsp_valid,  0);
        check("t4_rsp_rdata",  rsp_rdata,  0);
        check("t4_mem_read",   mem_read,   0);
        check("t4_mem_write",  mem_write,  0);
        check("t4_mem_addr",   mem_addr,   0);
        check("t4_mem_wd",     mem_wd,     0);
        check("t4_mem_funct3", mem_funct3, 0);
        check("t4_ready",      req_ready,  0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;

        // Requester 0 alone, continuously: grant every 2 cycles, ready[1] never
        drive(0, 1'b0, 9'h010, 32'h0, 3'b010);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_ready", req_ready, (k % 2 != 0) ? 2'b00 : 2'b01);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        // Misaligned word load: no strobes, error response
        issue(0, 1'b0, 9'h013, 32'h0, 3'b010);
        @(negedge clk);
        check("t6_mem_read",  mem_read,  0);
        check("t6_mem_write", mem_write, 0);
        @(negedge clk);
        check("t6_rsp_valid", rsp_valid, 2'b01);
        check("t6_rsp_err",   rsp_err,   1);
        check("t6_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
